// File: rtl/axi_lite_mem_arbiter.sv
// Round-robin arbiter sharing one AXI-lite master between the fetch port (0) and load/store port (1).
// One transaction in flight at a time; all requester and AXI outputs come straight from registers.
module axi_lite_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // port 0 (instruction fetch)
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [STRB_W-1:0] p0_wstrb,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    // port 1 (load/store)
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [STRB_W-1:0] p1_wstrb,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    // AXI-lite master
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP, DONE} state_t;

    state_t              state_reg;
    logic                rr_ptr_reg;
    logic                winner_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                err_reg;
    logic                awvalid_reg;
    logic                wvalid_reg;
    logic                arvalid_reg;
    logic                rready_reg;
    logic                bready_reg;
    logic [1:0]          gnt_reg;
    logic [1:0]          done_reg;
    logic [1:0]          port_err_reg;
    logic [DATA_W-1:0]   port_rdata_reg [2];

    logic [1:0]          req_vec;
    logic                winner_next;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;
    logic                aw_fin;
    logic                w_fin;

    always_comb begin
        req_vec     = {p1_req, p0_req};
        // With a single requester it wins outright; on contention rr_ptr picks.
        winner_next = (req_vec == 2'b11) ? rr_ptr_reg : req_vec[1];
        sel_we      = winner_next ? p1_we    : p0_we;
        sel_addr    = winner_next ? p1_addr  : p0_addr;
        sel_wdata   = winner_next ? p1_wdata : p0_wdata;
        sel_wstrb   = winner_next ? p1_wstrb : p0_wstrb;
        // A channel is finished once its valid has dropped or is handshaking now.
        aw_fin      = !awvalid_reg || m_awready;
        w_fin       = !wvalid_reg  || m_wready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= 1'b0;
            winner_reg   <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b0;
            arvalid_reg  <= 1'b0;
            rready_reg   <= 1'b0;
            bready_reg   <= 1'b0;
            gnt_reg      <= '0;
            done_reg     <= '0;
            port_err_reg <= '0;
            for (int i = 0; i < 2; i++) port_rdata_reg[i] <= '0;
        end else begin
            gnt_reg      <= '0;
            done_reg     <= '0;
            port_err_reg <= '0;
            for (int i = 0; i < 2; i++) port_rdata_reg[i] <= '0;

            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        winner_reg           <= winner_next;
                        addr_reg             <= sel_addr;
                        wdata_reg            <= sel_wdata;
                        wstrb_reg            <= sel_wstrb;
                        gnt_reg[winner_next] <= 1'b1;
                        rr_ptr_reg           <= ~winner_next;
                        if (sel_we) begin
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= WADDR;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= RADDR;
                        end
                    end
                end
                RADDR: begin
                    if (m_arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_rvalid) begin
                        rdata_reg  <= m_rdata;
                        err_reg    <= (m_rresp != 2'b00);
                        rready_reg <= 1'b0;
                        state_reg  <= DONE;
                    end
                end
                WADDR: begin
                    if (awvalid_reg && m_awready) awvalid_reg <= 1'b0;
                    if (wvalid_reg && m_wready)   wvalid_reg  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready_reg <= 1'b1;
                        state_reg  <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_bvalid) begin
                        err_reg    <= (m_bresp != 2'b00);
                        rdata_reg  <= '0;
                        bready_reg <= 1'b0;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    done_reg[winner_reg]       <= 1'b1;
                    port_rdata_reg[winner_reg] <= rdata_reg;
                    port_err_reg[winner_reg]   <= err_reg;
                    state_reg                  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign p0_gnt    = gnt_reg[0];
    assign p1_gnt    = gnt_reg[1];
    assign p0_done   = done_reg[0];
    assign p1_done   = done_reg[1];
    assign p0_rdata  = port_rdata_reg[0];
    assign p1_rdata  = port_rdata_reg[1];
    assign p0_err    = port_err_reg[0];
    assign p1_err    = port_err_reg[1];

    assign m_awaddr  = addr_reg;
    assign m_awvalid = awvalid_reg;
    assign m_wdata   = wdata_reg;
    assign m_wstrb   = wstrb_reg;
    assign m_wvalid  = wvalid_reg;
    assign m_bready  = bready_reg;
    assign m_araddr  = addr_reg;
    assign m_arvalid = arvalid_reg;
    assign m_rready  = rready_reg;

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Scoreboard bench for axi_lite_mem_arbiter: directed vectors plus short random mixed traffic
// against a delay-configurable AXI-lite slave model.
`timescale 1ns/1ps
module tb_axi_lite_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [63:0] p0_addr = '0, p0_wdata = '0;
    logic [7:0]  p0_wstrb = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [63:0] p1_addr = '0, p1_wdata = '0;
    logic [7:0]  p1_wstrb = '0;
    logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [63:0] p0_rdata, p1_rdata;

    logic [63:0] m_awaddr, m_araddr, m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic        m_arready = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
    logic [63:0] m_rdata = '0;

    axi_lite_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STRB_W(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // ---------------- slave model (updates 1 ns after each rising edge) ----------------
    int          ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
    logic [1:0]  rresp_k = 2'b00, bresp_k = 2'b00;
    logic [63:0] rom [logic [63:0]];
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        end else begin
            if (m_arready) begin m_arready = 0; ar_cnt = 0; end
            else if (m_arvalid) begin if (ar_cnt >= ar_dly) m_arready = 1; else ar_cnt++; end
            if (m_awready) begin m_awready = 0; aw_cnt = 0; end
            else if (m_awvalid) begin if (aw_cnt >= aw_dly) m_awready = 1; else aw_cnt++; end
            if (m_wready) begin m_wready = 0; w_cnt = 0; end
            else if (m_wvalid) begin if (w_cnt >= w_dly) m_wready = 1; else w_cnt++; end
            if (m_rvalid) begin m_rvalid = 0; r_cnt = 0; end
            else if (m_rready) begin
                if (r_cnt >= r_dly) begin
                    m_rvalid = 1;
                    m_rdata  = rom.exists(m_araddr) ? rom[m_araddr] : 64'h0;
                    m_rresp  = rresp_k;
                end else r_cnt++;
            end
            if (m_bvalid) begin m_bvalid = 0; b_cnt = 0; end
            else if (m_bready) begin
                if (b_cnt >= b_dly) begin m_bvalid = 1; m_bresp = bresp_k; end
                else b_cnt++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          port;
        logic [63:0] rdata;
        bit          err;
        int          lat;     // gnt-to-done cycles, -1 = not checked
    } exp_t;

    exp_t        exp_q [$];
    logic [63:0] exp_ar [$];
    logic [63:0] exp_aw [$];
    logic [71:0] exp_w [$];
    int          n_cmp = 0, n_fail = 0, cyc = 0;
    int          gnt_cyc [2] = '{-1, -1};
    logic        rst_seen = 1'b1;
    bit          end_req = 0, end_ack = 0;
    logic        prev_ar_stall = 0, prev_aw_stall = 0, prev_w_stall = 0;
    logic [63:0] prev_araddr = '0, prev_awaddr = '0;
    logic [71:0] prev_w = '0;

    always @(posedge clk) rst_seen <= rst;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_seen) begin
            chk("reset_state",
                128'({m_awvalid, m_wvalid, m_arvalid, m_rready, m_bready, p0_gnt, p1_gnt,
                      p0_done, p1_done, p0_err, p1_err, |p0_rdata, |p1_rdata}), 128'(0));
            gnt_cyc[0] = -1;
            gnt_cyc[1] = -1;
            prev_ar_stall = 0; prev_aw_stall = 0; prev_w_stall = 0;
        end else begin
            if (p0_gnt) gnt_cyc[0] = cyc;
            if (p1_gnt) gnt_cyc[1] = cyc;
            if (prev_ar_stall) chk("ar_stable", 128'({m_arvalid, m_araddr}), 128'({1'b1, prev_araddr}));
            if (prev_aw_stall) chk("aw_stable", 128'({m_awvalid, m_awaddr}), 128'({1'b1, prev_awaddr}));
            if (prev_w_stall)  chk("w_stable", 128'({m_wvalid, m_wstrb, m_wdata}), 128'({1'b1, prev_w}));
            if (m_arvalid && m_arready) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", 128'(m_araddr), 128'(0) - 128'(1));
                else chk("ar_addr", 128'(m_araddr), 128'(exp_ar.pop_front()));
            end
            if (m_awvalid && m_awready) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 128'(m_awaddr), 128'(0) - 128'(1));
                else chk("aw_addr", 128'(m_awaddr), 128'(exp_aw.pop_front()));
            end
            if (m_wvalid && m_wready) begin
                if (exp_w.size() == 0) chk("w_unexpected", 128'({m_wstrb, m_wdata}), 128'(0) - 128'(1));
                else chk("w_strb_data", 128'({m_wstrb, m_wdata}), 128'(exp_w.pop_front()));
            end
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? p0_done : p1_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 128'(p), 128'(2));
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_port", 128'(p), 128'(e.port));
                        chk("rdata", 128'((p == 0) ? p0_rdata : p1_rdata), 128'(e.rdata));
                        chk("err", 128'((p == 0) ? p0_err : p1_err), 128'(e.err));
                        chk("other_port_quiet",
                            128'((p == 0) ? {p1_err, p1_rdata} : {p0_err, p0_rdata}), 128'(0));
                        chk("gnt_seen", 128'(gnt_cyc[p] >= 0), 128'(1));
                        if (e.lat >= 0) chk("gnt_to_done", 128'(cyc - gnt_cyc[p]), 128'(e.lat));
                    end
                    gnt_cyc[p] = -1;
                end
            end
            prev_ar_stall = m_arvalid && !m_arready;
            prev_aw_stall = m_awvalid && !m_awready;
            prev_w_stall  = m_wvalid && !m_wready;
            prev_araddr   = m_araddr;
            prev_awaddr   = m_awaddr;
            prev_w        = {m_wstrb, m_wdata};
        end
        if (end_req && !end_ack) begin
            chk("leftover_expect", 128'({exp_q.size(), exp_ar.size(), exp_aw.size(), exp_w.size()}), 128'(0));
            end_ack = 1;
        end
    end

    // ---------------- stimulus ----------------
    bit rr_model = 0;

    task automatic expect_txn(input bit p, input bit we, input logic [63:0] addr, input logic [63:0] wd,
                              input logic [7:0] st, input logic [63:0] rd, input bit err, input int lat);
        exp_t e;
        e.port  = p;
        e.rdata = we ? 64'h0 : rd;
        e.err   = err;
        e.lat   = lat;
        exp_q.push_back(e);
        if (we) begin
            exp_aw.push_back(addr);
            exp_w.push_back({st, wd});
        end else begin
            exp_ar.push_back(addr);
        end
    endtask

    task automatic drive(input bit p, input bit we, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [7:0] st);
        if (p == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_wstrb = st; p0_req = 1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_wstrb = st; p1_req = 1;
        end
    endtask

    // Requesters hold until their own done; optionally corrupt fields once granted.
    task automatic run_until_idle(input int budget, input bit scramble);
        int n = 0;
        while ((p0_req || p1_req) && n < budget) begin
            @(negedge clk);
            n++;
            if (scramble && p0_gnt) begin p0_addr = ~p0_addr; p0_wdata = ~p0_wdata; p0_wstrb = ~p0_wstrb; end
            if (scramble && p1_gnt) begin p1_addr = ~p1_addr; p1_wdata = ~p1_wdata; p1_wstrb = ~p1_wstrb; end
            if (p0_done) p0_req = 0;
            if (p1_done) p1_req = 0;
        end
        if (p0_req || p1_req) begin
            $display("FAIL timeout: request still pending after %0d cycles (got req=%b%b, expected 00)",
                     budget, p1_req, p0_req);
            $fatal(1, "bench aborted on timeout");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        p0_req = 0; p1_req = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        rr_model = 0;
    endtask

    initial begin
        bit          we_a [2];
        logic [63:0] addr_a [2], wd_a [2];
        logic [7:0]  st_a [2];
        logic [63:0] rd_addrs [4];
        int          mask, wt;
        bit          first;

        rom[64'h1000] = 64'hDEAD_BEEF_0123_4567;
        rom[64'h2000] = 64'h1111_2222_3333_4444;
        rom[64'h3000] = 64'hAAAA_5555_CCCC_3333;
        rom[64'h9000] = 64'h0000_0000_0000_0077;
        rom[64'h4000] = 64'h4444_4444_4444_4444;
        rd_addrs[0] = 64'h1000; rd_addrs[1] = 64'h2000; rd_addrs[2] = 64'h3000; rd_addrs[3] = 64'h9000;

        do_reset();

        // 1: zero-wait p0 read
        expect_txn(0, 0, 64'h1000, 64'h0, 8'h00, 64'hDEAD_BEEF_0123_4567, 0, 3);
        drive(0, 0, 64'h1000, 64'h0, 8'h00);
        run_until_idle(50, 0);

        // 2: simultaneous requests after reset alternate, p0 first
        do_reset();
        expect_txn(0, 0, 64'h2000, 64'h0, 8'h00, 64'h1111_2222_3333_4444, 0, 3);
        expect_txn(1, 0, 64'h3000, 64'h0, 8'h00, 64'hAAAA_5555_CCCC_3333, 0, 3);
        drive(0, 0, 64'h2000, 64'h0, 8'h00);
        drive(1, 0, 64'h3000, 64'h0, 8'h00);
        run_until_idle(80, 0);
        expect_txn(0, 1, 64'h2008, 64'h0123, 8'hFF, 64'h0, 0, 3);
        expect_txn(1, 0, 64'h3000, 64'h0, 8'h00, 64'hAAAA_5555_CCCC_3333, 0, 3);
        drive(0, 1, 64'h2008, 64'h0123, 8'hFF);
        drive(1, 0, 64'h3000, 64'h0, 8'h00);
        run_until_idle(80, 0);
        // 2b: after a lone p0 grant the pointer favours p1
        expect_txn(0, 0, 64'h2000, 64'h0, 8'h00, 64'h1111_2222_3333_4444, 0, 3);
        drive(0, 0, 64'h2000, 64'h0, 8'h00);
        run_until_idle(50, 0);
        expect_txn(1, 1, 64'h3010, 64'hCAFE, 8'h0F, 64'h0, 0, 3);
        expect_txn(0, 0, 64'h1000, 64'h0, 8'h00, 64'hDEAD_BEEF_0123_4567, 0, 3);
        drive(0, 0, 64'h1000, 64'h0, 8'h00);
        drive(1, 1, 64'h3010, 64'hCAFE, 8'h0F);
        run_until_idle(80, 0);

        // 3: p1 write, W accepted 3 cycles before AW; fields scrambled after gnt
        aw_dly = 3;
        expect_txn(1, 1, 64'h8000_0008, 64'h55, 8'h01, 64'h0, 0, 6);
        drive(1, 1, 64'h8000_0008, 64'h55, 8'h01);
        run_until_idle(50, 1);
        aw_dly = 0;

        // 4: p1 read, SLVERR, rvalid 5 cycles late
        r_dly = 5; rresp_k = 2'b10;
        expect_txn(1, 0, 64'h9000, 64'h0, 8'h00, 64'h77, 1, 8);
        drive(1, 0, 64'h9000, 64'h0, 8'h00);
        run_until_idle(50, 0);
        r_dly = 0; rresp_k = 2'b00;

        // 5: reset while waiting in RDATA, then a fresh read
        r_dly = 10;
        exp_ar.push_back(64'h4000);
        drive(0, 0, 64'h4000, 64'h0, 8'h00);
        wt = 0;
        while (!m_rready && wt < 20) begin @(negedge clk); wt++; end
        rst = 1; p0_req = 0;
        @(negedge clk);
        rst = 0; r_dly = 0; rr_model = 0;
        repeat (2) @(negedge clk);
        expect_txn(0, 0, 64'h1000, 64'h0, 8'h00, 64'hDEAD_BEEF_0123_4567, 0, 3);
        drive(0, 0, 64'h1000, 64'h0, 8'h00);
        run_until_idle(50, 0);

        // 6: random mixed traffic with random stalls and responses
        do_reset();
        for (int it = 0; it < 60; it++) begin
            ar_dly = $urandom_range(0, 3); aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            rresp_k = 2'($urandom_range(0, 3)); bresp_k = 2'($urandom_range(0, 3));
            mask = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                we_a[p]   = 1'($urandom_range(0, 1));
                addr_a[p] = we_a[p] ? 64'($urandom_range(0, 255)) << 3 : rd_addrs[$urandom_range(0, 3)];
                wd_a[p]   = {32'($urandom), 32'($urandom)};
                st_a[p]   = 8'($urandom_range(0, 255));
            end
            first = (mask == 3) ? rr_model : (mask == 2);
            for (int k = 0; k < ((mask == 3) ? 2 : 1); k++) begin
                bit p;
                p = (k == 0) ? first : ~first;
                expect_txn(p, we_a[p], addr_a[p], wd_a[p], st_a[p],
                           we_a[p] ? 64'h0 : rom[addr_a[p]],
                           we_a[p] ? (bresp_k != 2'b00) : (rresp_k != 2'b00), -1);
                drive(p, we_a[p], addr_a[p], wd_a[p], st_a[p]);
                rr_model = ~p;
            end
            run_until_idle(200, 0);
        end

        end_req = 1;
        wt = 0;
        while (!end_ack && wt < 5) begin @(negedge clk); wt++; end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
